phoneme_playback_ctrl: RTL and testbench

PHONEME_PLAYBACK_CTRL -- requirements
Module: phoneme_playback_ctrl

---
 rtl/phoneme_playback_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_phoneme_playback_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phoneme_playback_ctrl.sv
// ============================================================================
// Module   : phoneme_playback_ctrl
// Brief    : Queues phoneme codes, looks up each code's sample range, and
//            streams its sample bytes out at the audio tick rate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phoneme_playback_ctrl #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 23
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [7:0]                 ph_code,
    input  logic                       ph_wr,
    input  logic                       abort,
    output logic                       fifo_full,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       ph_overflow,
    output logic                       tbl_rd,
    output logic [7:0]                 tbl_addr,
    input  logic [ADDR_W-1:0]          tbl_start,
    input  logic [ADDR_W-1:0]          tbl_end,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [7:0]                 mem_data,
    input  logic                       sample_tick,
    output logic [7:0]                 sample_out,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       ph_done,
    output logic [7:0]                 cur_phoneme,
    output logic [7:0]                 underrun_cnt
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_FETCH  = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [7:0]        r_fifo [DEPTH];
    logic [c_CW-1:0]   r_wr_ptr;
    logic [c_CW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [7:0]        w_head;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;
    logic [7:0]        r_hold;
    logic [7:0]        r_sample;
    logic              r_valid;
    logic              r_done;
    logic [7:0]        r_cur;
    logic              r_pend;
    logic [7:0]        r_underrun;
    logic              r_overflow;

    logic              w_take;
    logic              w_last;
    logic              w_range_bad;
    logic              w_tick_early;

    // Extra pointer bit distinguishes full from empty.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == c_CW'(DEPTH));
    assign w_empty     = (w_count == '0);
    assign w_head      = r_fifo[r_rd_ptr[c_PW-1:0]];
    assign w_push      = ph_wr && !w_full && !abort;
    assign w_pop       = (r_state == S_IDLE) && !w_empty && !abort;
    assign w_take      = (r_state == S_WAIT) && (sample_tick || r_pend);
    assign w_last      = (r_addr == r_end);
    assign w_range_bad = (tbl_start > tbl_end);
    assign w_tick_early = sample_tick && (r_state != S_IDLE) && (r_state != S_WAIT);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_pop) w_next_state = S_LOOKUP;
            S_LOOKUP: w_next_state = w_range_bad ? S_IDLE : S_FETCH;
            S_FETCH:  if (mem_ack) w_next_state = S_WAIT;
            S_WAIT:   if (w_take) w_next_state = w_last ? S_IDLE : S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
        if (abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy     = (r_state != S_IDLE);
        mem_req  = (r_state == S_FETCH);
        tbl_rd   = w_pop;
        tbl_addr = w_pop ? w_head : 8'h00;
    end

    // Queue storage carries no reset; emptiness is held by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PW-1:0]] <= ph_code;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_addr     <= '0;
            r_end      <= '0;
            r_hold     <= 8'h00;
            r_sample   <= 8'h80;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_cur      <= 8'h00;
            r_pend     <= 1'b0;
            r_underrun <= 8'h00;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (abort) begin
                r_rd_ptr   <= r_wr_ptr;
                r_overflow <= 1'b0;
                r_pend     <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_cur    <= w_head;
                end
                if (ph_wr && w_full) r_overflow <= 1'b1;

                if (r_state == S_LOOKUP) begin
                    r_addr <= tbl_start;
                    r_end  <= tbl_end;
                    r_done <= w_range_bad;
                end
                if ((r_state == S_FETCH) && mem_ack) begin
                    r_hold <= mem_data;
                end

                // A tick that lands while the previous one is still pending is lost.
                if (w_take) begin
                    r_sample <= r_hold;
                    r_valid  <= 1'b1;
                    r_pend   <= 1'b0;
                    if (w_last) r_done <= 1'b1;
                    else        r_addr <= r_addr + 1'b1;
                end else if (w_tick_early) begin
                    r_pend <= 1'b1;
                    if (r_pend && (r_underrun != 8'hFF)) begin
                        r_underrun <= r_underrun + 8'd1;
                    end
                end
            end
        end
    end

    assign fifo_full    = w_full;
    assign fifo_count   = w_count;
    assign ph_overflow  = r_overflow;
    assign mem_addr     = r_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign ph_done      = r_done;
    assign cur_phoneme  = r_cur;
    assign underrun_cnt = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_phoneme_playback_ctrl.sv
// ============================================================================
// Module   : tb_phoneme_playback_ctrl
// Brief    : Scoreboard bench for phoneme_playback_ctrl with table/memory models.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phoneme_playback_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  ph_code;
    logic        ph_wr;
    logic        abort;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        ph_overflow;
    logic        tbl_rd;
    logic [7:0]  tbl_addr;
    logic [22:0] tbl_start;
    logic [22:0] tbl_end;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        sample_tick;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        busy;
    logic        ph_done;
    logic [7:0]  cur_phoneme;
    logic [7:0]  underrun_cnt;

    phoneme_playback_ctrl #(.DEPTH(4), .ADDR_W(23)) dut (
        .clk(clk), .reset_n(reset_n), .ph_code(ph_code), .ph_wr(ph_wr),
        .abort(abort), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .ph_overflow(ph_overflow), .tbl_rd(tbl_rd), .tbl_addr(tbl_addr),
        .tbl_start(tbl_start), .tbl_end(tbl_end), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .sample_tick(sample_tick), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .ph_done(ph_done),
        .cur_phoneme(cur_phoneme), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [22:0] tstart [256];
    logic [22:0] tend   [256];
    logic [7:0]  q_samp [$];
    logic [7:0]  q_done [$];
    logic [22:0] q_addr [$];

    int ack_dly  = 2;
    int tick_per = 0;
    bit stall    = 0;
    int n_req    = 0;
    int acnt     = 0;
    int tcnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] smp(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h3C;
    endfunction

    // Reference playback of one phoneme from the bench's own table.
    task automatic expect_ph(input logic [7:0] p);
        logic [22:0] a;
        a = tstart[p];
        if (tstart[p] <= tend[p]) begin
            forever begin
                q_addr.push_back(a);
                q_samp.push_back(smp(a));
                if (a == tend[p]) break;
                a = a + 23'd1;
            end
        end
        q_done.push_back(p);
    endtask

    task automatic wr(input logic [7:0] p);
        @(negedge clk);
        ph_code = p;
        ph_wr   = 1'b1;
        @(negedge clk);
        ph_wr   = 1'b0;
    endtask

    task automatic wait_req(input int maxc);
        int n;
        n = 0;
        while (!mem_req && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("wait_req_timeout", 32'(n < maxc), 1);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((q_samp.size() != 0 || q_done.size() != 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < maxc), 1);
        check("addr_queue_left", q_addr.size(), 0);
    endtask

    // Table model: range presented from the tbl_rd cycle through LOOKUP.
    always @(negedge clk) begin
        if (tbl_rd) begin
            tbl_start = tstart[tbl_addr];
            tbl_end   = tend[tbl_addr];
        end
    end

    // Sample memory model with programmable ack latency.
    always @(negedge clk) begin
        if (mem_req) n_req++;
        if (mem_ack) begin
            mem_ack = 1'b0;
            acnt    = 0;
        end else if (mem_req && !stall) begin
            acnt++;
            if (acnt >= ack_dly) begin
                mem_ack  = 1'b1;
                mem_data = smp(mem_addr);
                acnt     = 0;
                if (q_addr.size() == 0) check("unexpected_fetch", 1, 0);
                else check("mem_addr", mem_addr, q_addr.pop_front());
            end
        end else begin
            acnt = 0;
        end
    end

    always @(negedge clk) begin
        if (tick_per == 0) begin
            sample_tick = 1'b0;
            tcnt        = 0;
        end else begin
            tcnt++;
            sample_tick = (tcnt >= tick_per);
            if (sample_tick) tcnt = 0;
        end
    end

    // Output monitor: every sample and phoneme end is matched to the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_valid) begin
                if (q_samp.size() == 0) check("unexpected_sample", 1, 0);
                else check("sample_out", sample_out, q_samp.pop_front());
            end
            if (ph_done) begin
                if (q_done.size() == 0) check("unexpected_ph_done", 1, 0);
                else check("done_phoneme", cur_phoneme, q_done.pop_front());
            end
        end
    end

    initial begin
        int u0;
        reset_n = 1'b0;
        ph_code = 8'h00;
        ph_wr = 1'b0;
        abort = 1'b0;
        mem_ack = 1'b0;
        mem_data = 8'h00;
        tbl_start = '0;
        tbl_end = '0;
        sample_tick = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tstart[i] = 23'h0;
            tend[i]   = 23'h0;
        end
        tstart[8'h05] = 23'h100;    tend[8'h05] = 23'h102;
        tstart[8'h11] = 23'h10;     tend[8'h11] = 23'h0F;
        for (int i = 0; i < 5; i++) begin
            tstart[8'h20 + i] = 23'h200 + 23'(16 * i);
            tend[8'h20 + i]   = 23'h201 + 23'(16 * i);
        end
        tstart[8'h40] = 23'h400;    tend[8'h40] = 23'h402;
        tstart[8'h50] = 23'h500;    tend[8'h50] = 23'h501;
        tstart[8'h30] = 23'h7FFFFF; tend[8'h30] = 23'h7FFFFF;
        tstart[8'h31] = 23'h0;      tend[8'h31] = 23'h0;

        repeat (3) @(negedge clk);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_sample_out", sample_out, 8'h80);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_tbl_rd", tbl_rd, 0);
        check("rst_underrun", underrun_cnt, 0);
        check("rst_overflow", ph_overflow, 0);
        check("rst_cur_phoneme", cur_phoneme, 0);
        reset_n = 1'b1;

        // Single phoneme, three samples
        tick_per = 20;
        ack_dly  = 2;
        expect_ph(8'h05);
        wr(8'h05);
        check("single_tbl_rd", tbl_rd, 1);
        check("single_tbl_addr", tbl_addr, 8'h05);
        drain(2000);
        check("single_busy", busy, 0);
        check("single_hold", sample_out, smp(23'h102));

        // start > end: ph_done two cycles after tbl_rd, no fetch
        expect_ph(8'h11);
        n_req = 0;
        wr(8'h11);
        check("sgt_tbl_rd", tbl_rd, 1);
        @(negedge clk);
        check("sgt_done_early", ph_done, 0);
        @(negedge clk);
        check("sgt_done", ph_done, 1);
        check("sgt_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("sgt_no_req", n_req, 0);

        // Overflow while fetch is stalled
        stall = 1;
        expect_ph(8'h20);
        wr(8'h20);
        wait_req(20);
        for (int i = 1; i < 5; i++) begin
            expect_ph(8'(8'h20 + i));
            wr(8'(8'h20 + i));
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag_pre", ph_overflow, 0);
        wr(8'h25);
        check("ovf_flag", ph_overflow, 1);
        check("ovf_count_hold", fifo_count, 4);
        stall = 0;
        drain(5000);
        check("ovf_sticky", ph_overflow, 1);

        // Underrun: slow memory relative to tick rate
        ack_dly = 50;
        u0 = int'(underrun_cnt);
        expect_ph(8'h40);
        wr(8'h40);
        drain(5000);
        check("undr_delta_range", 32'((int'(underrun_cnt) - u0 >= 3) && (int'(underrun_cnt) - u0 <= 7)), 1);

        // Saturation, then abort with two queued phonemes
        ack_dly = 2;
        stall = 1;
        tick_per = 1;
        wr(8'h50);
        wait_req(20);
        wr(8'h51);
        wr(8'h52);
        check("abort_count_pre", fifo_count, 2);
        repeat (300) @(negedge clk);
        check("undr_saturate", underrun_cnt, 8'hFF);
        check("abort_req_pre", mem_req, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_mem_req", mem_req, 0);
        check("abort_count", fifo_count, 0);
        check("abort_busy", busy, 0);
        check("abort_overflow", ph_overflow, 0);
        tick_per = 0;
        stall = 0;
        repeat (20) @(negedge clk);
        check("abort_idle", busy, 0);

        // Address extremes, back to back
        tick_per = 20;
        expect_ph(8'h30);
        expect_ph(8'h31);
        wr(8'h30);
        wr(8'h31);
        drain(3000);
        check("wrap_hold", sample_out, smp(23'h0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
